midori64_ti_round_ctrl: RTL
===========================

// Module: midori64_ti_round_ctrl
// PURPOSE
//  Sequencing FSM for the Midori64 threshold-implementation round datapath.
//  Drives the sel input of every select_register_64 share register: load plaintext shares, then loop round output.
//  Tracks round and S-box pipeline stage; flags last round, key parity, whitening cycles; start/busy/done handshake.
//  Sits between top-level control and the share datapath; no data passes through it.
// PARAMETERS
//  ROUNDS   16  total Midori64 rounds incl. final (15 full + 1 final); legal 2..16
//  STAGES   2   register stages per round in the TI S-box pipeline; legal 1..4
//  RW       4   round_idx width, >= clog2(ROUNDS)
//  SW       2   stage_idx width, >= max(1,clog2(STAGES))
// PORTS
//  clk         in   1   rising-edge clock
//  rst         in   1   synchronous, active-high reset
//  start       in   1   begin encryption; sampled only in IDLE
//  sel         out  1   share-register mux: 1 = load input shares, 0 = feed round output
//  busy        out  1   high ROUND/FINAL/DONE
//  done        out  1   one-cycle pulse; share registers hold ciphertext shares
//  round_idx   out  RW  current round 0..ROUNDS-1 (round-constant index)
//  stage_idx   out  SW  current pipeline stage 0..STAGES-1
//  key_sel     out  1   round_idx[0]: selects round key K0/K1
//  last_round  out  1   high in FINAL: datapath bypasses ShuffleCell/MixColumn
//  wk_en       out  1   whitening-key XOR enable: IDLE, and FINAL at stage STAGES-1
// BEHAVIOUR
//  - One clock, clk; reset synchronous active-high on rst; all outputs are registered (Moore) or decoded from registered state only.
//  - Reset values: state=IDLE, sel=1, busy=0, done=0, round_idx=0, stage_idx=0, key_sel=0, last_round=0, wk_en=1.
//  - IDLE: sel=1, so share registers track whitened input every cycle. start=1 at edge E0 -> ROUND, round=0, stage=0.
//  - ROUND: sel=0. stage increments each cycle; at stage==STAGES-1, stage->0 and round++.
//  - ROUND exit: at stage==STAGES-1 and round==ROUNDS-2 -> FINAL, round=ROUNDS-1, stage=0.
//  - FINAL: sel=0, last_round=1; STAGES cycles; at stage==STAGES-1 -> DONE.
//  - DONE: one cycle, done=1, sel=0, round/stage hold; next edge -> IDLE with round=0, stage=0.
//  - Latency: done is high in the cycle after edge E0+ROUNDS*STAGES. Defaults: 32 edges.
//  - start outside IDLE is ignored; no queueing. start held high in DONE's following IDLE cycle restarts normally.
//  - rst has priority over every transition; reset mid-encryption returns to IDLE immediately. Data in flight is discarded.
//  - Counters never wrap: the round counter saturates by construction at ROUNDS-1; the stage counter is modulo STAGES.
//  - No illegal-state lockup: unused state encodings decode to IDLE on the next edge.
// STRUCTURE
//  - Shared include midori64_ti_defs.vh: state encodings (IDLE=0, ROUND=1, FINAL=2, DONE=3), ROUNDS/STAGES defaults, round-constant table beta[0..14].
//  - Sub-module round_stage_counter: stage modulo STAGES plus round counter with wrap/terminal flags; instantiated once.
//  - The FSM and output decode live in this module; constant lookup stays in the datapath.
// TESTING
//  - Reset: rst=1 for 2 cycles mid-ROUND (round=5) -> next cycle sel=1, busy=0, round_idx=0, stage_idx=0, done=0.
//  - Nominal, defaults: start pulse at E0 -> sel=0 from E0+1, last_round=1 edges 30..31, done=1 exactly after edge 32, then IDLE.
//  - Sequence check: round_idx steps 0,0,1,1,..,15,15 and key_sel=round_idx[0]; wk_en high only at stage 1 of FINAL while busy.
//  - start held high for 40 cycles -> a single accepted start, then a restart at the IDLE after DONE; no double-accept.
//  - Parameter sweep STAGES=1, ROUNDS=2 -> ROUND 1 cycle, FINAL 1 cycle, done 2 edges after start.
//  - Parameter sweep STAGES=4, ROUNDS=16 -> done 64 edges after start.
//  - Reset in DONE cycle -> done drops next cycle; no spurious second pulse.

Source files
------------

// File: rtl/midori64_ti_round_ctrl_pkg.sv
// Shared definitions for the Midori64 threshold-implementation round controller:
// state encodings and default round/pipeline geometry.
package midori64_ti_round_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int ROUNDS_DEF = 16;
  localparam int STAGES_DEF = 2;

endpackage

// File: rtl/midori64_ti_round_ctrl_counter.sv
// Round/stage position tracker: stage counts modulo STAGES, round advances on
// each stage wrap and never passes ROUNDS-1.
module round_stage_counter #(
  parameter int ROUNDS = 16,
  parameter int STAGES = 2,
  parameter int RW     = 4,
  parameter int SW     = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [RW-1:0] round_idx,
  output logic [SW-1:0] stage_idx,
  output logic          stage_last,
  output logic          round_penult
);

  assign stage_last   = (stage_idx == SW'(STAGES - 1));
  assign round_penult = (round_idx == RW'(ROUNDS - 2));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      round_idx <= '0;
      stage_idx <= '0;
    end else if (en) begin
      if (stage_last) begin
        stage_idx <= '0;
        // Saturate: the FINAL round's wrap must not roll the index over.
        if (round_idx != RW'(ROUNDS - 1))
          round_idx <= round_idx + 1'b1;
      end else begin
        stage_idx <= stage_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/midori64_ti_round_ctrl.sv
// Sequencing FSM for the Midori64 TI share datapath: load shares in IDLE, loop
// round output through ROUND/FINAL, pulse done, and flag key/whitening cycles.
module midori64_ti_round_ctrl
  import midori64_ti_round_ctrl_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF,
  parameter int STAGES = STAGES_DEF,
  parameter int RW     = 4,
  parameter int SW     = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          sel,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] round_idx,
  output logic [SW-1:0] stage_idx,
  output logic          key_sel,
  output logic          last_round,
  output logic          wk_en
);

  state_t state, ns;
  logic   stage_last, round_penult, cnt_clr, cnt_en;

  // Counters restart from zero whenever the next run could begin, and freeze
  // on the last FINAL stage so DONE shows the terminal position.
  assign cnt_clr = (state == ST_IDLE) || (state == ST_DONE);
  assign cnt_en  = (state == ST_ROUND) || ((state == ST_FINAL) && !stage_last);

  round_stage_counter #(
    .ROUNDS(ROUNDS),
    .STAGES(STAGES),
    .RW    (RW),
    .SW    (SW)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr         (cnt_clr),
    .en          (cnt_en),
    .round_idx   (round_idx),
    .stage_idx   (stage_idx),
    .stage_last  (stage_last),
    .round_penult(round_penult)
  );

  always_comb begin
    ns = ST_IDLE;
    case (state)
      ST_IDLE:  ns = start ? ST_ROUND : ST_IDLE;
      ST_ROUND: ns = (stage_last && round_penult) ? ST_FINAL : ST_ROUND;
      ST_FINAL: ns = stage_last ? ST_DONE : ST_FINAL;
      ST_DONE:  ns = ST_IDLE;
      default:  ns = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sel        <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      last_round <= 1'b0;
    end else begin
      state      <= ns;
      sel        <= (ns == ST_IDLE);
      busy       <= (ns != ST_IDLE);
      done       <= (ns == ST_DONE);
      last_round <= (ns == ST_FINAL);
    end
  end

  // Input whitening while idle; output whitening on the closing FINAL stage.
  assign wk_en   = (state == ST_IDLE) || ((state == ST_FINAL) && stage_last);
  assign key_sel = round_idx[0];

endmodule
